// File: rtl/sparc_ram_ctrl_if.sv
// Request/response bus between a master and the byte-serial RAM controller.
// The access-size field is named acc_type because "type" is a reserved word.
interface sparc_ram_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              MOV;       // memory operation valid
  logic              r_w;       // 1 = read, 0 = write
  logic [1:0]        acc_type;  // 00 byte, 01 halfword, 1x word
  logic [ADDR_W-1:0] Address;   // byte address of the most significant byte
  logic [31:0]       DataIn;    // write data, right-justified
  logic [31:0]       DataOut;   // read data, right-justified, zero-extended
  logic              MOC;       // memory operation complete
  logic              Err;       // misaligned access, valid while MOC = 1
  logic              Busy;      // transfer in progress

  modport master (
    output MOV, r_w, acc_type, Address, DataIn,
    input  DataOut, MOC, Err, Busy
  );

  modport slave (
    input  MOV, r_w, acc_type, Address, DataIn,
    output DataOut, MOC, Err, Busy
  );
endinterface

// File: rtl/sparc_ram_ctrl.sv
// Byte-serial big-endian RAM controller: byte, halfword and word accesses
// are moved one byte per clock between an 8-bit wide store and a 32-bit bus.
module sparc_ram_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input logic            Clk,
  input logic            Clr,
  sparc_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];

  logic              rw_q;
  logic              first_q;
  logic              err_q;
  logic [1:0]        cnt_q;      // bytes still to move after the current one
  logic [31:0]       dout_q;
  logic [31:0]       data_q;     // write data, left-justified, shifted out MSB-first
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;

  logic              accept;
  logic              misalign;
  logic              last;
  logic              wr_en;
  logic [7:0]        rd_byte;
  logic              moc;
  logic              busy;

  function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] a_lo);
    return ((t == 2'b01) && a_lo[0]) || (t[1] && (a_lo != 2'b00));
  endfunction

  function automatic logic [1:0] bytes_m1(input logic [1:0] t);
    case (t)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] left_justify(input logic [1:0] t, input logic [31:0] d);
    case (t)
      2'b00:   return {d[7:0], 24'h000000};
      2'b01:   return {d[15:0], 16'h0000};
      default: return d;
    endcase
  endfunction

  assign accept   = (state == IDLE) && bus.MOV;
  assign misalign = is_misaligned(bus.acc_type, bus.Address[1:0]);
  assign last     = (cnt_q == 2'd0);
  assign wr_en    = (state == XFER) && !rw_q;
  assign rd_byte  = mem[addr_q];
  assign addr_inc = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc;
  assign bus.Err     = err_q;
  assign bus.Busy    = busy;

  // State register; reset returns to IDLE at once
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    moc       = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MOV) state_nxt = misalign ? DONE : XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        moc  = 1'b1;
        if (!bus.MOV) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, byte counting, error flag and read-data assembly
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rw_q    <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      dout_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MOV) begin
            rw_q    <= bus.r_w;
            first_q <= 1'b1;
            err_q   <= misalign;
            cnt_q   <= bytes_m1(bus.acc_type);
          end
        end
        XFER: begin
          cnt_q   <= cnt_q - 2'd1;
          first_q <= 1'b0;
          // first byte of a read also clears the stale upper bits
          if (rw_q) dout_q <= first_q ? {24'h000000, rd_byte} : {dout_q[23:0], rd_byte};
        end
        DONE: begin
          if (!bus.MOV) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Address walk and write-data shifter; pure datapath, not reset
  always_ff @(posedge Clk) begin
    if (accept) begin
      addr_q <= bus.Address;
      data_q <= left_justify(bus.acc_type, bus.DataIn);
    end else if (state == XFER) begin
      addr_q <= addr_inc;
      data_q <= {data_q[23:0], 8'h00};
    end
  end

  // Byte store; contents survive reset
  always_ff @(posedge Clk) begin
    if (wr_en) mem[addr_q] <= data_q[31:24];
  end

endmodule

// File: tb/tb_sparc_ram_ctrl.sv
// Randomized bench for sparc_ram_ctrl with a transaction-level memory model
// and a per-cycle compare of MOC, Busy, Err and DataOut.
module tb_sparc_ram_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic clk;
  logic clr;

  sparc_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  sparc_ram_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  ref_mem [DEPTH];
  logic        exp_moc, exp_busy, exp_err;
  logic [31:0] exp_dout;
  bit          chk_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected bus state
  always @(negedge clk) begin
    if (chk_en) begin
      check("MOC",     32'(bus.MOC),  32'(exp_moc));
      check("Busy",    32'(bus.Busy), 32'(exp_busy));
      check("Err",     32'(bus.Err),  32'(exp_err));
      check("DataOut", bus.DataOut,   exp_dout);
    end
  end

  task automatic scramble(input bit mov);
    bus.MOV      = mov;
    bus.r_w      = 1'($urandom);
    bus.acc_type = 2'($urandom);
    bus.Address  = 9'($urandom);
    bus.DataIn   = $urandom;
  endtask

  // One complete access. hold = edges MOV stays high once MOC is up;
  // drop = release MOV right after acceptance. lat = index of the first
  // edge (sampling edge = 1) after which MOC was observed high.
  task automatic access(input bit rw, input logic [1:0] ty, input logic [8:0] a,
                        input logic [31:0] din, input int hold, input bit drop,
                        output logic [31:0] rd, output int lat);
    int n, e, h, ad;
    bit mis;
    logic [31:0] acc;
    n   = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    mis = ((ty == 2'b01) && a[0]) || (ty[1] && (a[1:0] != 2'b00));
    lat = 0; e = 0; acc = 32'h0; h = hold;
    bus.MOV = 1'b1; bus.r_w = rw; bus.acc_type = ty; bus.Address = a; bus.DataIn = din;
    @(posedge clk); #1; e++;
    if (lat == 0 && bus.MOC) lat = e;
    exp_busy = 1'b1;
    if (mis) begin
      exp_moc = 1'b1;
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        scramble(!drop);
        @(posedge clk); #1; e++;
        if (lat == 0 && bus.MOC) lat = e;
        ad = (int'(a) + k) % DEPTH;
        if (rw) begin
          acc      = {acc[23:0], ref_mem[ad]};
          exp_dout = acc;
        end else begin
          ref_mem[ad] = din[8*(n-1-k) +: 8];
        end
      end
      exp_moc = 1'b1;
      exp_err = 1'b0;
      if (drop) h = 0;
    end
    for (int j = h; j >= 0; j--) begin
      scramble(j > 0);
      @(posedge clk); #1; e++;
      if (lat == 0 && bus.MOC) lat = e;
      if (j == 0) begin
        exp_moc  = 1'b0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
      end
    end
    bus.MOV = 1'b0;
    rd = bus.DataOut;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          rw, mis;
    logic [1:0]  ty;
    logic [8:0]  a;
    int          n;

    clr = 1'b1; chk_en = 1'b1;
    exp_moc = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_dout = 32'h0;
    bus.MOV = 1'b0; bus.r_w = 1'b0; bus.acc_type = 2'b00; bus.Address = '0; bus.DataIn = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_MOC",     32'(bus.MOC),  32'h0);
    check("rst_Busy",    32'(bus.Busy), 32'h0);
    check("rst_DataOut", bus.DataOut,   32'h0);
    clr = 1'b0;

    // Fill the whole store so every later read has a known model value
    for (int w = 0; w < DEPTH / 4; w++)
      access(1'b0, 2'b10, 9'(w * 4), $urandom, 0, 1'($urandom), rd, lat);

    // Word write then word read
    access(1'b0, 2'b10, 9'h004, 32'hDEADBEEF, 0, 1'b0, rd, lat);
    check("wr_word_lat", lat, 5);
    access(1'b0 ^ 1'b1, 2'b10, 9'h004, 32'h0, 1, 1'b0, rd, lat);
    check("rd_word_data", rd, 32'hDEADBEEF);
    check("rd_word_lat", lat, 5);

    // Byte and halfword reads of the same word
    access(1'b1, 2'b00, 9'h005, 32'h0, 0, 1'b0, rd, lat);
    check("rd_byte_data", rd, 32'h000000AD);
    check("rd_byte_lat", lat, 2);
    access(1'b1, 2'b01, 9'h006, 32'h0, 0, 1'b1, rd, lat);
    check("rd_half_data", rd, 32'h0000BEEF);
    check("rd_half_lat", lat, 3);

    // Misaligned word write: immediate MOC with Err, nothing changes
    access(1'b0, 2'b10, 9'h002, 32'h12345678, 2, 1'b0, rd, lat);
    check("mis_lat", lat, 1);
    check("mis_dout_kept", rd, 32'h0000BEEF);
    for (int b = 2; b < 6; b++) begin
      access(1'b1, 2'b00, 9'(b), 32'h0, 0, 1'b0, rd, lat);
      check("mis_mem_kept", rd, {24'h0, ref_mem[b]});
    end
    check("mis_mem_lit4", rd & 32'h0 | {24'h0, ref_mem[4]}, 32'h000000DE);

    // MOV held high for 10 edges through a byte read
    access(1'b1, 2'b00, 9'h007, 32'h0, 8, 1'b0, rd, lat);
    check("hold_rd_data", rd, 32'h000000EF);
    check("hold_rd_lat", lat, 2);

    // Reset in the middle of a word write
    bus.MOV = 1'b1; bus.r_w = 1'b0; bus.acc_type = 2'b10; bus.Address = 9'h010; bus.DataIn = 32'h11223344;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    scramble(1'b0);
    @(posedge clk); #1; ref_mem[16] = 8'h11;
    @(posedge clk); #1; ref_mem[17] = 8'h22;
    #2;
    clr = 1'b1;
    exp_moc = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_dout = 32'h0;
    #1;
    check("clr_MOC",     32'(bus.MOC),  32'h0);
    check("clr_Busy",    32'(bus.Busy), 32'h0);
    check("clr_Err",     32'(bus.Err),  32'h0);
    check("clr_DataOut", bus.DataOut,   32'h0);
    @(posedge clk); #1;
    clr = 1'b0;
    access(1'b1, 2'b00, 9'h010, 32'h0, 0, 1'b0, rd, lat);
    check("clr_keep_010", rd, 32'h00000011);
    check("clr_first_lat", lat, 2);
    access(1'b1, 2'b00, 9'h011, 32'h0, 0, 1'b0, rd, lat);
    check("clr_keep_011", rd, 32'h00000022);
    access(1'b1, 2'b00, 9'h012, 32'h0, 0, 1'b0, rd, lat);
    check("clr_untouched_012", rd, {24'h0, ref_mem[18]});

    // Top-of-memory word: no wrap into address 0
    access(1'b0, 2'b10, 9'h1FC, 32'hCAFEF00D, 0, 1'b0, rd, lat);
    access(1'b1, 2'b10, 9'h1FC, 32'h0, 0, 1'b0, rd, lat);
    check("top_word", rd, 32'hCAFEF00D);
    access(1'b1, 2'b01, 9'h1FE, 32'h0, 0, 1'b0, rd, lat);
    check("top_half", rd, 32'h0000F00D);
    access(1'b1, 2'b10, 9'h000, 32'h0, 0, 1'b0, rd, lat);
    check("no_wrap_000", rd, {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]});

    // Randomized accesses
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom);
      ty = 2'($urandom);
      a  = 9'($urandom);
      if ($urandom_range(0, 4) != 0) begin
        if (ty == 2'b01) a[0] = 1'b0;
        else if (ty[1]) a[1:0] = 2'b00;
      end
      n   = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
      mis = ((ty == 2'b01) && a[0]) || (ty[1] && (a[1:0] != 2'b00));
      access(rw, ty, a, $urandom, $urandom_range(0, 3), 1'($urandom), rd, lat);
      check("rand_lat", lat, mis ? 1 : n + 1);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparc_ram_ctrl.md
SPARC_RAM_CTRL -- requirements
Module: sparc_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning byte-address width.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the number of 8-bit storage locations.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port MOV, input, 1, memory operation valid (request).
REQ-006 SHALL have port r_w, input, 1, 1=read, 0=write.
REQ-007 SHALL have port type, input, 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 SHALL have port Address, input, ADDR_W, byte address of the most significant byte.
REQ-009 SHALL have port DataIn, input, 32, write data, right-justified.
REQ-010 SHALL have port DataOut, output, 32, read data, right-justified, zero-extended.
REQ-011 SHALL have port MOC, output, 1, memory operation complete.
REQ-012 SHALL have port Err, output, 1, misaligned access flag, valid while MOC=1.
REQ-013 SHALL have port Busy, output, 1, high while a transfer is in progress.

Function
REQ-014 SHALL hold DEPTH x 8-bit storage, big-endian: byte at Address is most significant.
REQ-015 SHALL implement FSM states IDLE, XFER, DONE.
REQ-016 IDLE: on MOV=1 at a rising edge, SHALL latch r_w, type, Address, DataIn; go to XFER, or to DONE with Err=1 if misaligned.
REQ-017 Misaligned: halfword with Address[0]=1, word with Address[1:0]!=00; SHALL leave memory and DataOut unchanged.
REQ-018 XFER SHALL move exactly one byte per cycle: 1, 2 or 4 cycles for byte, halfword or word.
REQ-019 Write SHALL store latched DataIn bytes MSB-first at Address, Address+1, ... in successive cycles.
REQ-020 Read SHALL shift each byte into DataOut from the LSB end; DataOut upper bits SHALL be zero after byte/halfword reads.
REQ-021 DataOut SHALL clear to 0 on the first XFER cycle of a read and is otherwise only changed by reads.
REQ-022 After the last byte, SHALL enter DONE; MOC=1 and Err valid from the first DONE cycle.
REQ-023 Latency: aligned access of N bytes SHALL give MOC=1 exactly N+1 edges after the edge sampling MOV.
REQ-024 DONE SHALL hold MOC=1 until MOV is sampled 0, then return to IDLE with MOC=0 the next cycle.
REQ-025 If MOV is already 0 on entry to DONE, MOC SHALL be high for exactly one cycle.
REQ-026 MOV deasserting or changing inputs during XFER SHALL NOT abort or alter the transfer.
REQ-027 A new request SHALL only be accepted in IDLE; MOV held high across DONE SHALL NOT start a second access.
REQ-028 Busy SHALL be 1 in XFER and DONE, 0 in IDLE.
REQ-029 Internal byte address SHALL increment modulo DEPTH; aligned accesses never wrap.
REQ-030 Err SHALL clear when leaving DONE.

Reset
REQ-031 Clr=1 SHALL immediately force IDLE, MOC=0, Err=0, Busy=0, DataOut=0.
REQ-032 Reset SHALL NOT clear storage; bytes already written by an interrupted write SHALL remain.
REQ-033 After Clr falls, the first rising edge with MOV=1 SHALL start a new access normally.

Verification
REQ-034 Write word 0xDEADBEEF at 0x004, then read word 0x004 -> DataOut=0xDEADBEEF, MOC on 5th edge, Err=0.
REQ-035 Read byte 0x005 after REQ-034 -> DataOut=0x000000AD; read halfword 0x006 -> 0x0000BEEF.
REQ-036 Word write at 0x002 -> MOC=1, Err=1 on 1st edge, memory 0x002..0x005 unchanged.
REQ-037 MOV held high 10 cycles through a byte read -> exactly one access, MOC high until MOV low, then 0.
REQ-038 Clr pulsed after 2 bytes of a word write of 0x11223344 at 0x010 -> MOC=0, DataOut=0, bytes 0x010=0x11, 0x011=0x22 retained.
REQ-039 Word write at 0x1FC, then read -> data correct, no wrap into 0x000.
